// File: rtl/riscv_mtimer_pkg.sv
// Register map indices and CTRL field offsets for the riscv_mtimer block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_mtimer_pkg;

    localparam int MTIME_IDX = 0;
    localparam int PRESC_IDX = 1;
    localparam int CTRL_IDX  = 2;
    localparam int CMP_BASE  = 3;

    // CTRL layout: channel enables from bit 0, pending flags from bit 16.
    localparam int CTRL_EN_LSB   = 0;
    localparam int CTRL_PEND_LSB = 16;

    // PERIOD registers follow the CMP bank, so their base moves with NUM_CMP.
    function automatic int period_base(input int num_cmp);
        return CMP_BASE + num_cmp;
    endfunction

endpackage

// File: rtl/riscv_mtimer_cmp_ch.sv
// One compare channel: CMP register, optional PERIOD/pending reload logic, compare.
// Latency: irq_nxt is combinational; the top registers it (one edge after the condition).
// Backpressure: none; register writes are accepted every cycle.
//
// Ports: clk/rst, en (current enable), mtime, cmp_we + wdata (CMP write),
//        reload build only: period_we, pend_clr (write-1-to-clear strobe), en_nxt, period;
//        outputs cmp, pending (flag readable via CTRL), irq_nxt (next irq level).
// Optional feature: RISCV_MTIMER_AUTORELOAD_EN adds PERIOD and sticky pending flags.
module riscv_mtimer_cmp_ch #(
    parameter int MXLEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [MXLEN-1:0] mtime,
    input  logic             cmp_we,
    input  logic [MXLEN-1:0] wdata,
`ifdef RISCV_MTIMER_AUTORELOAD_EN
    input  logic             period_we,
    input  logic             pend_clr,
    input  logic             en_nxt,
    output logic [MXLEN-1:0] period,
`endif
    output logic [MXLEN-1:0] cmp,
    output logic             pending,
    output logic             irq_nxt
);

    logic cond;

    assign cond = en && (mtime >= cmp);

`ifdef RISCV_MTIMER_AUTORELOAD_EN
    logic reload;
    logic pend_d;

    assign reload = cond && (period != '0);
    // A reload in the same cycle as a software clear keeps the flag set.
    assign pend_d = reload || (pending && !pend_clr);
    // PERIOD=0 falls back to the plain level interrupt.
    assign irq_nxt = (period == '0) ? cond : (pend_d && en_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp     <= '1;
            period  <= '0;
            pending <= 1'b0;
        end else begin
            // A software write to CMP overrides the automatic advance.
            if (cmp_we)
                cmp <= wdata;
            else if (reload)
                cmp <= cmp + period;
            if (period_we)
                period <= wdata;
            pending <= pend_d;
        end
    end
`else
    assign pending = cond;
    assign irq_nxt = cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmp <= '1;
        else if (cmp_we)
            cmp <= wdata;
    end
`endif

endmodule

// File: rtl/riscv_mtimer.sv
// Machine timer: prescaled 64-bit MTIME, NUM_CMP masked compare channels, register port.
// Latency: writes land at the edge; reads are combinational; irq one edge after the condition.
// Backpressure: none; one register access per cycle, always accepted.
//
// Ports: i_riscv_mtimer_clk/rst (async active-high), wren/rden/regsel/wdata register port,
//        o_riscv_mtimer_rdata (0 when idle or unmapped), o_riscv_mtimer_time (MTIME),
//        o_riscv_mtimer_irq (per channel, registered), o_riscv_mtimer_irq_any (registered OR).
// Optional feature: define RISCV_MTIMER_AUTORELOAD_EN for PERIOD auto-reload and W1C pending.
module riscv_mtimer
    import riscv_mtimer_pkg::*;
#(
    parameter int MXLEN    = 64,
    parameter int NUM_CMP  = 4,
    parameter int PRESC_W  = 16,
    parameter int REGSEL_W = $clog2(3 + 2 * NUM_CMP)
) (
    input  logic                i_riscv_mtimer_clk,
    input  logic                i_riscv_mtimer_rst,
    input  logic                i_riscv_mtimer_wren,
    input  logic                i_riscv_mtimer_rden,
    input  logic [REGSEL_W-1:0] i_riscv_mtimer_regsel,
    input  logic [MXLEN-1:0]    i_riscv_mtimer_wdata,
    output logic [MXLEN-1:0]    o_riscv_mtimer_rdata,
    output logic [MXLEN-1:0]    o_riscv_mtimer_time,
    output logic [NUM_CMP-1:0]  o_riscv_mtimer_irq,
    output logic                o_riscv_mtimer_irq_any
);

    localparam int PERIOD_BASE = period_base(NUM_CMP);

    logic                clk;
    logic                rst;
    logic [PRESC_W-1:0]  prescale_q;
    logic [PRESC_W-1:0]  presc_cnt_q;
    logic [MXLEN-1:0]    mtime_q;
    logic [NUM_CMP-1:0]  en_q;
    logic [NUM_CMP-1:0]  en_nxt;
    logic [NUM_CMP-1:0]  irq_q;
    logic [NUM_CMP-1:0]  irq_nxt;
    logic [NUM_CMP-1:0]  pending;
    logic                irq_any_q;
    logic                tick;
    logic                presc_we;
    logic                mtime_we;
    logic                ctrl_we;
    logic [NUM_CMP-1:0]  cmp_we;
    logic [MXLEN-1:0]    cmp_val [NUM_CMP];
`ifdef RISCV_MTIMER_AUTORELOAD_EN
    logic [NUM_CMP-1:0]  period_we;
    logic [NUM_CMP-1:0]  pend_clr;
    logic [MXLEN-1:0]    period_val [NUM_CMP];
`endif

    assign clk = i_riscv_mtimer_clk;
    assign rst = i_riscv_mtimer_rst;

    assign presc_we = i_riscv_mtimer_wren && (i_riscv_mtimer_regsel == REGSEL_W'(PRESC_IDX));
    assign mtime_we = i_riscv_mtimer_wren && (i_riscv_mtimer_regsel == REGSEL_W'(MTIME_IDX));
    assign ctrl_we  = i_riscv_mtimer_wren && (i_riscv_mtimer_regsel == REGSEL_W'(CTRL_IDX));

    // The prescaler counter never exceeds PRESCALE because a PRESCALE write clears it.
    assign tick   = (presc_cnt_q == prescale_q);
    assign en_nxt = ctrl_we ? i_riscv_mtimer_wdata[CTRL_EN_LSB +: NUM_CMP] : en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            mtime_q     <= '0;
            en_q        <= '0;
            irq_q       <= '0;
            irq_any_q   <= 1'b0;
        end else begin
            if (presc_we)
                prescale_q <= i_riscv_mtimer_wdata[PRESC_W-1:0];
            if (presc_we || tick)
                presc_cnt_q <= '0;
            else
                presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
            // A write replaces MTIME outright; the coincident tick is consumed, not deferred.
            if (mtime_we)
                mtime_q <= i_riscv_mtimer_wdata;
            else if (tick)
                mtime_q <= mtime_q + MXLEN'(1);
            en_q      <= en_nxt;
            irq_q     <= irq_nxt;
            irq_any_q <= |irq_nxt;
        end
    end

    for (genvar k = 0; k < NUM_CMP; k++) begin : g_ch
        assign cmp_we[k] = i_riscv_mtimer_wren &&
                           (i_riscv_mtimer_regsel == REGSEL_W'(CMP_BASE + k));
`ifdef RISCV_MTIMER_AUTORELOAD_EN
        assign period_we[k] = i_riscv_mtimer_wren &&
                              (i_riscv_mtimer_regsel == REGSEL_W'(PERIOD_BASE + k));
        assign pend_clr[k]  = ctrl_we && i_riscv_mtimer_wdata[CTRL_PEND_LSB + k];
`endif

        riscv_mtimer_cmp_ch #(
            .MXLEN(MXLEN)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en_q[k]),
            .mtime    (mtime_q),
            .cmp_we   (cmp_we[k]),
            .wdata    (i_riscv_mtimer_wdata),
`ifdef RISCV_MTIMER_AUTORELOAD_EN
            .period_we(period_we[k]),
            .pend_clr (pend_clr[k]),
            .en_nxt   (en_nxt[k]),
            .period   (period_val[k]),
`endif
            .cmp      (cmp_val[k]),
            .pending  (pending[k]),
            .irq_nxt  (irq_nxt[k])
        );
    end

    // Without the reload feature PERIOD indices fall through and read as 0.
    always_comb begin
        o_riscv_mtimer_rdata = '0;
        if (i_riscv_mtimer_rden) begin
            if (i_riscv_mtimer_regsel == REGSEL_W'(MTIME_IDX))
                o_riscv_mtimer_rdata = mtime_q;
            if (i_riscv_mtimer_regsel == REGSEL_W'(PRESC_IDX))
                o_riscv_mtimer_rdata = MXLEN'(prescale_q);
            if (i_riscv_mtimer_regsel == REGSEL_W'(CTRL_IDX)) begin
                o_riscv_mtimer_rdata[CTRL_EN_LSB +: NUM_CMP]   = en_q;
                o_riscv_mtimer_rdata[CTRL_PEND_LSB +: NUM_CMP] = pending;
            end
            for (int k = 0; k < NUM_CMP; k++) begin
                if (i_riscv_mtimer_regsel == REGSEL_W'(CMP_BASE + k))
                    o_riscv_mtimer_rdata = cmp_val[k];
`ifdef RISCV_MTIMER_AUTORELOAD_EN
                if (i_riscv_mtimer_regsel == REGSEL_W'(PERIOD_BASE + k))
                    o_riscv_mtimer_rdata = period_val[k];
`endif
            end
        end
    end

    assign o_riscv_mtimer_time    = mtime_q;
    assign o_riscv_mtimer_irq     = irq_q;
    assign o_riscv_mtimer_irq_any = irq_any_q;

endmodule

// File: tb/tb_riscv_mtimer.sv
// Self-checking bench for riscv_mtimer: reset-value table, prescaler, compare, wrap,
// write-vs-tick, async reset and (when RISCV_MTIMER_AUTORELOAD_EN is defined) auto-reload.
// Register reads go through an expected-value queue popped when rdata is sampled.
module tb_riscv_mtimer;

    localparam int MXLEN    = 64;
    localparam int NUM_CMP  = 4;
    localparam int PRESC_W  = 16;
    localparam int REGSEL_W = $clog2(3 + 2 * NUM_CMP);
    localparam int NREGS    = 1 << REGSEL_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                wren = 1'b0;
    logic                rden = 1'b0;
    logic [REGSEL_W-1:0] regsel = '0;
    logic [MXLEN-1:0]    wdata = '0;
    logic [MXLEN-1:0]    rdata;
    logic [MXLEN-1:0]    mtime;
    logic [NUM_CMP-1:0]  irq;
    logic                irq_any;

    always #5 clk = ~clk;

    riscv_mtimer #(
        .MXLEN   (MXLEN),
        .NUM_CMP (NUM_CMP),
        .PRESC_W (PRESC_W),
        .REGSEL_W(REGSEL_W)
    ) dut (
        .i_riscv_mtimer_clk    (clk),
        .i_riscv_mtimer_rst    (rst),
        .i_riscv_mtimer_wren   (wren),
        .i_riscv_mtimer_rden   (rden),
        .i_riscv_mtimer_regsel (regsel),
        .i_riscv_mtimer_wdata  (wdata),
        .o_riscv_mtimer_rdata  (rdata),
        .o_riscv_mtimer_time   (mtime),
        .o_riscv_mtimer_irq    (irq),
        .o_riscv_mtimer_irq_any(irq_any)
    );

    typedef struct {
        logic [REGSEL_W-1:0] sel;
        logic [MXLEN-1:0]    exp;
    } vec_t;

    vec_t             rst_tbl [NREGS];
    logic [MXLEN-1:0] sb_q [$];
    int               n_cmp = 0;
    int               n_bad = 0;

    task automatic chk(input string name, input logic [MXLEN-1:0] act, input logic [MXLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [MXLEN-1:0] d);
        regsel = REGSEL_W'(sel);
        wdata  = d;
        wren   = 1'b1;
        step();
        wren   = 1'b0;
    endtask

    // Drive a read, queue its expectation, then pop and compare once rdata settles.
    task automatic rd(input int sel, input logic [MXLEN-1:0] exp, input logic en, input string name);
        logic [MXLEN-1:0] e;
        regsel = REGSEL_W'(sel);
        rden   = en;
        sb_q.push_back(exp);
        #1;
        e = sb_q.pop_front();
        chk(name, rdata, e);
        rden = 1'b0;
    endtask

    task automatic wait_time(input logic [MXLEN-1:0] v, input int budget, input string name);
        int i;
        i = 0;
        while (mtime !== v && i < budget) begin
            step();
            i++;
        end
        if (mtime !== v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, mtime %0h never reached %0h", name, mtime, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values: MTIME, PRESCALE, CTRL 0; CMP all-ones; PERIOD and unmapped 0.
        for (int i = 0; i < NREGS; i++) begin
            rst_tbl[i].sel = REGSEL_W'(i);
            rst_tbl[i].exp = (i >= 3 && i < 3 + NUM_CMP) ? '1 : '0;
        end

        #12;
        for (int i = 0; i < NREGS; i++)
            rd(int'(rst_tbl[i].sel), rst_tbl[i].exp, 1'b1, $sformatf("reset_rd_sel%0d", i));
        chk("reset_time", mtime, '0);
        chk("reset_irq", MXLEN'(irq), '0);
        chk("reset_irq_any", MXLEN'(irq_any), '0);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // Prescaler 3: after the MTIME=0 write the count sits at 1, so
        // j edges later MTIME must equal (j+1)/4.
        wr(1, 3);
        wr(0, 0);
        chk("presc_start", mtime, 0);
        for (int j = 1; j <= 40; j++) begin
            step();
            chk($sformatf("presc_j%0d", j), mtime, MXLEN'((j + 1) / 4));
        end
        rd(0, 10, 1'b1, "presc_rd_mtime");
        rd(1, 3, 1'b1, "presc_rd_prescale");

        // Compare channel 0 at 20 with a tick every cycle.
        wr(1, 0);
        wr(3, 20);
        wr(2, 1);
        wr(0, 0);
        chk("cmp_irq_low", MXLEN'(irq), '0);
        wait_time(20, 60, "cmp_wait20");
        chk("cmp_irq_not_yet", MXLEN'(irq[0]), 0);
`ifdef RISCV_MTIMER_AUTORELOAD_EN
        rd(2, 64'h1, 1'b1, "cmp_rd_ctrl");
`else
        rd(2, 64'h1_0001, 1'b1, "cmp_rd_ctrl");
`endif
        step();
        chk("cmp_irq_rise", MXLEN'(irq[0]), 1);
        chk("cmp_irq_any_rise", MXLEN'(irq_any), 1);
        wr(3, 100);
        step();
        chk("cmp_irq_fall", MXLEN'(irq[0]), 0);
        chk("cmp_irq_any_fall", MXLEN'(irq_any), 0);
        rd(0, 0, 1'b0, "rden_low_reads_zero");
        rd(3, 100, 1'b1, "cmp_rd_cmp0");

        // Wrap: channel 1 at all-ones fires once, then drops after the wrap.
        wr(2, 2);
        wr(0, 64'hFFFF_FFFF_FFFF_FFFE);
        rd(0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "wrap_rd_fe");
        chk("wrap_irq_pre", MXLEN'(irq[1]), 0);
        step();
        rd(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "wrap_rd_ff");
        chk("wrap_irq_ff", MXLEN'(irq[1]), 0);
        step();
        rd(0, 0, 1'b1, "wrap_rd_0");
        chk("wrap_irq_hi", MXLEN'(irq[1]), 1);
        step();
        chk("wrap_irq_drop", MXLEN'(irq[1]), 0);

        // MTIME write on a tick cycle loads exactly, no lost or doubled increment.
        wr(0, 500);
        rd(0, 500, 1'b1, "wtick_rd_500");
        step();
        rd(0, 501, 1'b1, "wtick_rd_501");
        wr(1, 2);
        step(2);
        wr(0, 500);
        rd(0, 500, 1'b1, "wtick_p2_500");
        step(2);
        chk("wtick_p2_hold", mtime, 500);
        step();
        chk("wtick_p2_501", mtime, 501);

        // Asynchronous reset mid-count clears everything without a clock edge.
        wr(1, 0);
        wr(2, 3);
        step();
        chk("arst_irq_before", MXLEN'(irq[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_time", mtime, '0);
        chk("arst_irq", MXLEN'(irq), '0);
        chk("arst_irq_any", MXLEN'(irq_any), '0);
        rd(3, '1, 1'b1, "arst_rd_cmp0");
        rd(2, '0, 1'b1, "arst_rd_ctrl");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef RISCV_MTIMER_AUTORELOAD_EN
        // Auto-reload on channel 1: CMP 10 -> 15 -> 20, pending W1C in between.
        wr(4, 10);
        wr(3 + NUM_CMP + 1, 5);
        wr(2, 2);
        wr(0, 0);
        rd(3 + NUM_CMP + 1, 5, 1'b1, "rl_rd_period");
        wait_time(10, 40, "rl_wait10");
        chk("rl_irq_pre", MXLEN'(irq[1]), 0);
        step();
        rd(4, 15, 1'b1, "rl_rd_cmp15");
        chk("rl_irq_latch", MXLEN'(irq[1]), 1);
        rd(2, 64'h2_0002, 1'b1, "rl_rd_ctrl_pend");
        wait_time(12, 10, "rl_wait12");
        chk("rl_irq_held", MXLEN'(irq[1]), 1);
        wr(2, 64'h2_0002);
        chk("rl_irq_cleared", MXLEN'(irq[1]), 0);
        wait_time(15, 10, "rl_wait15");
        chk("rl_irq_low15", MXLEN'(irq[1]), 0);
        step();
        chk("rl_irq_reassert", MXLEN'(irq[1]), 1);
        rd(4, 20, 1'b1, "rl_rd_cmp20");
`else
        // PERIOD registers do not exist: writes are dropped, reads are 0.
        wr(3 + NUM_CMP + 1, 5);
        rd(3 + NUM_CMP + 1, 0, 1'b1, "noperiod_rd");
        rd(3 + NUM_CMP + 1, 0, 1'b1, "noperiod_rd_again");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
